// File: rtl/fir_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_capture_pkg
// Description : Shared types and constants for the FIR result capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_capture_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 64;

  // Status words sit directly after the sample window, at DEPTH + offset
  localparam int ADDR_COUNT_OFS = 0;
  localparam int ADDR_DROP_OFS  = 1;

  typedef enum logic [0:0] {
    CAPTURE = 1'b0,
    FULL    = 1'b1
  } cap_state_e;

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : capture_ram
// Description : DEPTH x DATA_W RAM, one write port, asynchronous read, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ram
  import fir_capture_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fir_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : fir_result_capture
// Description : Captures DEPTH filter samples, flags done, serves a host read map.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_result_capture
  import fir_capture_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [31:0]       regAddr,
  output logic [31:0]       regData,
  output logic              done
);

  localparam int AW      = $clog2(DEPTH);
  localparam int C_CNT_W = AW + 1;
  localparam logic [AW:0] c_last      = C_CNT_W'(DEPTH - 1);
  localparam logic [31:0] c_cnt_addr  = 32'(DEPTH + ADDR_COUNT_OFS);
  localparam logic [31:0] c_drop_addr = 32'(DEPTH + ADDR_DROP_OFS);

  cap_state_e        r_state, w_state_nxt;
  logic [AW:0]       r_wr_cnt, w_wr_cnt_nxt;
  logic [31:0]       r_drop_cnt, w_drop_cnt_nxt;
  logic              r_done, w_done_nxt;
  logic              w_we;
  logic [DATA_W-1:0] w_rd_data;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_wr_cnt32;

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (w_we),
    .waddr (r_wr_cnt[AW-1:0]),
    .wdata (in_data),
    .raddr (regAddr[AW-1:0]),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= CAPTURE;
      r_wr_cnt   <= '0;
      r_drop_cnt <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // clear wins over in_valid: the coincident sample is neither stored nor dropped
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    w_drop_cnt_nxt = r_drop_cnt;
    w_done_nxt     = r_done;
    w_we           = 1'b0;
    if (clear) begin
      w_state_nxt    = CAPTURE;
      w_wr_cnt_nxt   = '0;
      w_drop_cnt_nxt = '0;
      w_done_nxt     = 1'b0;
    end else if (in_valid) begin
      case (r_state)
        CAPTURE: begin
          w_we         = 1'b1;
          w_wr_cnt_nxt = r_wr_cnt + C_CNT_W'(1);
          if (r_wr_cnt == c_last) begin
            w_state_nxt = FULL;
            w_done_nxt  = 1'b1;
          end
        end
        FULL: begin
          if (r_drop_cnt != '1) begin
            w_drop_cnt_nxt = r_drop_cnt + 32'd1;
          end
        end
        default: w_state_nxt = CAPTURE;
      endcase
    end
  end

  if (DATA_W >= 32) begin : g_rd_trunc
    assign w_rd_word = w_rd_data[31:0];
  end else begin : g_rd_zext
    assign w_rd_word = {{(32 - DATA_W){1'b0}}, w_rd_data};
  end

  assign w_wr_cnt32 = 32'(r_wr_cnt);

  // Slots at or above wr_cnt read as zero so stale RAM contents never leak out
  always_comb begin
    regData = '0;
    if (regAddr < w_wr_cnt32) begin
      regData = w_rd_word;
    end else if (regAddr == c_cnt_addr) begin
      regData = w_wr_cnt32;
    end else if (regAddr == c_drop_addr) begin
      regData = r_drop_cnt;
    end
  end

  assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fir_result_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_result_capture
// Description : Self-checking bench: read-map tables plus scoreboarded sample runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_result_capture;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [31:0]       regAddr = '0;
  logic [31:0]       regData;
  logic              done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_q [$];

  typedef struct {
    int          phase;
    string       name;
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t tab [10];

  fir_result_capture #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .in_valid (in_valid),
    .in_data  (in_data),
    .regAddr  (regAddr),
    .regData  (regData),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One clock: inputs set at negedge, returns 1 time unit after the posedge
  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic clr);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    clear    = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    regAddr = a;
    #1;
    check(nm, regData, e);
  endtask

  task automatic rd_cyc(input string nm, input logic [31:0] a, input logic [31:0] e);
    @(negedge clk);
    regAddr = a;
    #1;
    check(nm, regData, e);
  endtask

  task automatic run_table(input int ph);
    for (int i = 0; i < 10; i++) begin
      if (tab[i].phase == ph) rd_cyc(tab[i].name, tab[i].addr, tab[i].exp);
    end
  endtask

  // Feed DEPTH samples base+1..base+DEPTH, checking done timing on the last edges
  task automatic full_run(input logic [31:0] base);
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, base + 32'(i), 1'b0);
      exp_q.push_back(base + 32'(i));
      if (i == DEPTH - 1) check("done_before_last", 32'(done), 32'd0);
      if (i == DEPTH)     check("done_on_last", 32'(done), 32'd1);
    end
    idle();
  endtask

  task automatic sweep();
    for (int a = 0; a < DEPTH; a++) begin
      logic [31:0] e;
      if (exp_q.size() == 0) begin
        check("sweep_queue_underflow", 32'(a), 32'(DEPTH));
        break;
      end
      e = exp_q.pop_front();
      rd_cyc("sweep", 32'(a), e);
    end
  endtask

  initial begin
    tab[0] = '{0, "rst_addr0",    32'd0,          32'd0};
    tab[1] = '{0, "rst_count",    32'd64,         32'd0};
    tab[2] = '{0, "rst_drop",     32'd65,         32'd0};
    tab[3] = '{1, "full_count",   32'd64,         32'd64};
    tab[4] = '{1, "full_drop",    32'd65,         32'd0};
    tab[5] = '{1, "full_addr66",  32'd66,         32'd0};
    tab[6] = '{1, "full_wrap",    32'h8000_0005,  32'd0};
    tab[7] = '{1, "full_alias40", 32'h0000_0140,  32'd0};
    tab[8] = '{1, "full_allones", 32'hFFFF_FFFF,  32'd0};
    tab[9] = '{2, "ovf_drop",     32'd65,         32'd5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_done", 32'(done), 32'd0);
    run_table(0);

    // Full back-to-back run of 1..64
    full_run(32'd0);
    sweep();
    run_table(1);

    // Overflow: 5 extra samples are dropped, buffer untouched
    for (int i = 0; i < 5; i++) drive(1'b1, 32'hDEAD_0000 + 32'(i), 1'b0);
    idle();
    check("ovf_done", 32'(done), 32'd1);
    run_table(2);
    rd_cyc("ovf_count", 32'd64, 32'd64);
    for (int i = 1; i <= DEPTH; i++) exp_q.push_back(32'(i));
    sweep();

    // clear together with in_valid while FULL
    drive(1'b1, 32'h0000_0055, 1'b1);
    check("clr_done", 32'(done), 32'd0);
    rd("clr_count", 32'd64, 32'd0);
    rd("clr_drop", 32'd65, 32'd0);
    rd("clr_addr0", 32'd0, 32'd0);
    drive(1'b1, 32'h0000_0077, 1'b0);
    rd("clr_next_addr0", 32'd0, 32'h77);
    rd("clr_next_count", 32'd64, 32'd1);

    // Partial fill with gaps
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), 1'b0);
      if (i % 3 == 1) idle();
    end
    idle();
    rd("part_addr0", 32'd0, 32'hA0);
    rd("part_addr9", 32'd9, 32'hA9);
    rd("part_addr10", 32'd10, 32'd0);
    rd("part_count", 32'd64, 32'd10);
    check("part_done", 32'(done), 32'd0);

    // Same-cycle read and write of one slot returns the old value
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 32'hBB;
    regAddr  = 32'd10;
    #1;
    check("rdw_old", regData, 32'd0);
    @(posedge clk);
    #1;
    check("rdw_new", regData, 32'hBB);
    idle();

    // Asynchronous reset after 30 writes, then a clean run
    drive(1'b0, '0, 1'b1);
    for (int i = 0; i < 30; i++) drive(1'b1, 32'h200 + 32'(i), 1'b0);
    idle();
    rd("pre_rst_addr5", 32'd5, 32'h205);
    #1;
    reset = 1'b1;
    #1;
    check("arst_done", 32'(done), 32'd0);
    rd("arst_addr5", 32'd5, 32'd0);
    rd("arst_count", 32'd64, 32'd0);
    rd("arst_drop", 32'd65, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    full_run(32'h100);
    sweep();
    rd_cyc("rerun_count", 32'd64, 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
